// File: rtl/mem_pkg.sv
// Constants shared by mem_fifo and the mem single-port memory it drives.
package mem_pkg;

  localparam int unsigned MEM_ADDR = 4;
  localparam int unsigned MEM_WORD = 4;

  localparam logic [1:0] MEM_FIFO_IDLE     = 2'd0;
  localparam logic [1:0] MEM_FIFO_RD_ISSUE = 2'd1;
  localparam logic [1:0] MEM_FIFO_RD_WAIT  = 2'd2;

endpackage

// File: rtl/mem_fifo.sv
// Valid/ready FIFO controller on a single-port memory with a show-ahead output register.
// Optional MEM_FIFO_BYPASS_EN: a push into a completely empty FIFO loads the output register directly.
module mem_fifo
  import mem_pkg::*;
#(
  parameter int unsigned ADDR = MEM_ADDR,
  parameter int unsigned WORD = MEM_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [WORD-1:0]   push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [WORD-1:0]   pop_data,
  output logic [ADDR:0]     level,
  output logic [ADDR-1:0]   mem_addr,
  output logic [WORD-1:0]   mem_data_in,
  output logic              mem_wr,
  input  logic [WORD-1:0]   mem_data_out
);

  localparam int unsigned LVL_W = ADDR + 1;
  localparam int unsigned DEPTH = 32'd1 << ADDR;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [ADDR-1:0] wr_ptr;
  logic [ADDR-1:0] rd_ptr;
  logic [WORD-1:0] out_reg;
  logic            out_valid;
  logic            last_rd;
  logic            run;
  logic            full;
  logic            rd_req;
  logic            wr_gnt;
  logic            rd_gnt;
  logic            contend;
  logic            bypass;

  assign pop_valid = out_valid;
  assign pop_data  = out_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MEM_FIFO_IDLE;
    else        state <= state_nxt;
  end

  // Arbitration, next state and memory port drive
  always_comb begin
    state_nxt   = state;
    push_ready  = 1'b0;
    full        = (level == LVL_W'(DEPTH));
    rd_req      = (state == MEM_FIFO_IDLE) && !out_valid && (level != '0);
    // ready is held low until the first edge after reset so it reads 0 in reset
    case (state)
      MEM_FIFO_IDLE:    push_ready = run && !full && !(rd_req && !last_rd);
      MEM_FIFO_RD_WAIT: push_ready = run && !full;
      default:          push_ready = 1'b0;
    endcase
    wr_gnt  = push_valid && push_ready;
    contend = rd_req && push_valid && run && !full;
    rd_gnt  = rd_req && !wr_gnt;
`ifdef MEM_FIFO_BYPASS_EN
    bypass  = wr_gnt && (state == MEM_FIFO_IDLE) && (level == '0) && !out_valid;
`else
    bypass  = 1'b0;
`endif
    mem_wr      = wr_gnt && !bypass;
    mem_addr    = (state == MEM_FIFO_RD_ISSUE) ? rd_ptr : wr_ptr;
    mem_data_in = mem_wr ? push_data : '0;
    case (state)
      MEM_FIFO_IDLE:     if (rd_gnt) state_nxt = MEM_FIFO_RD_ISSUE;
      MEM_FIFO_RD_ISSUE: state_nxt = MEM_FIFO_RD_WAIT;
      MEM_FIFO_RD_WAIT:  state_nxt = MEM_FIFO_IDLE;
      default:           state_nxt = MEM_FIFO_IDLE;
    endcase
  end

  // Pointers, occupancy, arbitration history and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_reg   <= '0;
      out_valid <= 1'b0;
      last_rd   <= 1'b0;
      run       <= 1'b0;
    end else begin
      run <= 1'b1;
      if (mem_wr) wr_ptr <= wr_ptr + ADDR'(1);
      if (state == MEM_FIFO_RD_ISSUE) rd_ptr <= rd_ptr + ADDR'(1);
      if (mem_wr) level <= level + LVL_W'(1);
      else if (state == MEM_FIFO_RD_ISSUE) level <= level - LVL_W'(1);
      if (contend) last_rd <= rd_gnt;
      if (state == MEM_FIFO_RD_WAIT) begin
        out_reg   <= mem_data_out;
        out_valid <= 1'b1;
      end else if (bypass) begin
        out_reg   <= push_data;
        out_valid <= 1'b1;
      end else if (out_valid && pop_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
